polyphase_interpolator: RTL and testbench
=========================================

// Module: polyphase_interpolator
// PURPOSE
//   Upsample-by-M polyphase FIR: takes one input sample, emits M filtered output samples (one per phase).
//   Producer-side counterpart of the decimating MAC path; the sample stream runs in the opposite direction.
//   One time-multiplexed MAC, one tap per cycle. Coefficients are runtime-loaded. Valid/ready on both sides.
// PARAMETERS
//   SAMPLE_WIDTH  16  signed sample width, in and out
//   COEF_WIDTH    16  signed coefficient width, Q1.(COEF_WIDTH-1)
//   N             31  prototype filter length (total taps)
//   M             2   interpolation factor / number of phases
//   (derived) K = ceil(N/M) taps per phase; ACC_W = SAMPLE_WIDTH+COEF_WIDTH+$clog2(K)
// PORTS
//   clk         in   1             clock, rising edge
//   reset       in   1             reset, synchronous, active-high
//   valid_in    in   1             data_in valid
//   ready_in    out  1             block accepts data_in
//   data_in     in   SAMPLE_WIDTH  signed input sample
//   valid_out   out  1             data_out valid
//   ready_out   in   1             downstream accepts data_out
//   data_out    out  SAMPLE_WIDTH  signed interpolated sample
//   coef_we     in   1             coefficient write strobe
//   coef_addr   in   $clog2(N)     prototype tap index h[coef_addr]
//   coef_data   in   COEF_WIDTH    signed coefficient value
//   coef_ready  out  1             high when a coefficient write is honoured (IDLE only)
// BEHAVIOUR
//   Reset: state=IDLE; data_out=0; valid_out=0; ready_in=0 during reset; delay line, coefs, acc, phase, tap all 0.
//   FSM states: IDLE, MAC, OUT.
//   IDLE: ready_in=1, coef_ready=1. On valid_in: dline shifts (dline[0]<=data_in); phase<=0, tap<=0, acc<=0 -> MAC.
//   MAC: each cycle acc += coef[phase+tap*M] * dline[tap]. An index >= N contributes 0.
//        On tap==K-1: data_out<=sat(scale(acc_final)); valid_out<=1 -> OUT.
//   OUT: data_out is held stable while valid_out=1 && !ready_out.
//        On ready_out: valid_out<=0; if phase==M-1 -> IDLE, else phase++, tap<=0, acc<=0 -> MAC.
//   Latency: input accepted in cycle 0 -> first valid_out in cycle K+1. Output phases are spaced K+1 cycles apart
//        when ready_out=1. Throughput: one input per M*(K+1)+1 cycles.
//   ready_in=0 in MAC/OUT; valid_in is ignored there (upstream holds data).
//   Arithmetic: all signed. Product is COEF_WIDTH+SAMPLE_WIDTH bits; acc is ACC_W bits and cannot overflow.
//        scale = acc >>> (COEF_WIDTH-1), arithmetic shift.
//        sat clamps to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
//   Coefficients: coef_we with coef_ready=1 and coef_addr<N writes h[coef_addr]. coef_addr>=N is ignored.
//        coef_we while coef_ready=0 is dropped with no effect.
//   Simultaneous valid_in and coef_we in IDLE: both take effect; the new coefficient is used by the MAC that follows.
//   Reset mid-operation: the FSM aborts to IDLE. valid_out=0 in the cycle after reset. Any pending output is lost.
//        Coefficients and delay line are cleared.
//   Back-to-back inputs: the next valid_in is accepted in the first IDLE cycle after phase M-1 is consumed.
// CONFIGURATION
//   ROUND_EN defined: before the shift, add 2^(COEF_WIDTH-2) to acc (round half up), then saturate.
//   ROUND_EN undefined: truncate (floor) via arithmetic shift; no rounding adder is synthesized.
// TESTING  (N=31, M=2, K=16, widths 16)
//   Impulse: h[0]=16384, others 0; in 1000 then 0 -> out 500, 0, then 0, 0; valid_out at cycle 17, then 34.
//   Phase select: h[1]=32767, others 0; in 2000 -> out 0, 1999 (ROUND_EN: 0, 2000).
//   Saturation: all h=32767; 16 inputs of 32767 -> phase-0 out 32767. 16 inputs of -32768 -> out -32768.
//   Backpressure: ready_out=0 for 5 cycles in OUT -> data_out/valid_out stable, ready_in=0, no output lost or duplicated.
//   Coef gating: coef_we addr 0 during MAC -> coef_ready=0, write dropped, output unchanged. Same write in IDLE takes effect.
//   Reset mid-MAC: assert reset at tap 7 -> valid_out=0, ready_in=1 in the cycle after release; next impulse yields 0 (coefs cleared).

Source files
------------

// File: rtl/polyphase_interpolator.sv
// Upsample-by-M polyphase FIR, one shared MAC, one tap per cycle; outputs registered, K+1 cycles per phase.
// Ready_in drops for the whole M-phase burst; data_out is held while ready_out is low. Optional ROUND_EN macro.
module polyphase_interpolator #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int COEF_WIDTH   = 16,
  parameter int N            = 31,
  parameter int M            = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid_in,
  output logic                           ready_in,
  input  logic signed [SAMPLE_WIDTH-1:0] data_in,
  output logic                           valid_out,
  input  logic                           ready_out,
  output logic signed [SAMPLE_WIDTH-1:0] data_out,
  input  logic                           coef_we,
  input  logic [$clog2(N)-1:0]           coef_addr,
  input  logic signed [COEF_WIDTH-1:0]   coef_data,
  output logic                           coef_ready
);

  localparam int K      = (N + M - 1) / M;
  localparam int TAP_W  = (K > 1) ? $clog2(K) : 1;
  localparam int PH_W   = (M > 1) ? $clog2(M) : 1;
  localparam int CA_W   = $clog2(N);
  localparam int PROD_W = SAMPLE_WIDTH + COEF_WIDTH;
  localparam int ACC_W  = SAMPLE_WIDTH + COEF_WIDTH + $clog2(K);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                          state_q, state_d;
  logic [PH_W-1:0]                 phase_q, phase_d;
  logic [TAP_W-1:0]                tap_q, tap_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic signed [SAMPLE_WIDTH-1:0]  dout_q, dout_d;
  logic                            vout_q, vout_d;
  logic signed [SAMPLE_WIDTH-1:0]  dline_q [K];
  logic signed [COEF_WIDTH-1:0]    coef_q  [N];

  logic                            accept;
  logic                            coef_wr;
  logic [31:0]                     coef_idx;
  logic signed [COEF_WIDTH-1:0]    coef_sel;
  logic signed [PROD_W-1:0]        prod;
  logic signed [ACC_W-1:0]         acc_next;
  logic signed [ACC_W-1:0]         acc_rnd;
  logic signed [ACC_W-1:0]         scaled;
  logic [ACC_W-SAMPLE_WIDTH:0]     scaled_hi;
  logic signed [SAMPLE_WIDTH-1:0]  sat_val;

  // Polyphase tap mapping: phase p, tap t reads prototype h[p + t*M]; the tail past N is zero.
  always_comb begin
    coef_idx = 32'(phase_q) + 32'(tap_q) * 32'(M);
    coef_sel = '0;
    if (coef_idx < 32'(N)) coef_sel = coef_q[coef_idx[CA_W-1:0]];
    prod     = PROD_W'(coef_sel) * PROD_W'(dline_q[tap_q]);
    acc_next = acc_q + ACC_W'(prod);
  end

  always_comb begin
`ifdef ROUND_EN
    acc_rnd = acc_next + {{(ACC_W-COEF_WIDTH+1){1'b0}}, 1'b1, {(COEF_WIDTH-2){1'b0}}};
`else
    acc_rnd = acc_next;
`endif
    scaled    = acc_rnd >>> (COEF_WIDTH - 1);
    scaled_hi = scaled[ACC_W-1:SAMPLE_WIDTH-1];
    if (scaled_hi == '0 || scaled_hi == '1)
      sat_val = scaled[SAMPLE_WIDTH-1:0];
    else if (scaled[ACC_W-1])
      sat_val = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    else
      sat_val = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    tap_d      = tap_q;
    acc_d      = acc_q;
    dout_d     = dout_q;
    vout_d     = vout_q;
    accept     = 1'b0;
    ready_in   = 1'b0;
    coef_ready = 1'b0;
    case (state_q)
      IDLE: begin
        ready_in   = !reset;
        coef_ready = !reset;
        if (valid_in) begin
          accept  = 1'b1;
          phase_d = '0;
          tap_d   = '0;
          acc_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_next;
        if (tap_q == TAP_W'(K - 1)) begin
          dout_d  = sat_val;
          vout_d  = 1'b1;
          state_d = OUT;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      OUT: begin
        if (ready_out) begin
          vout_d = 1'b0;
          if (phase_q == PH_W'(M - 1)) begin
            state_d = IDLE;
          end else begin
            phase_d = phase_q + 1'b1;
            tap_d   = '0;
            acc_d   = '0;
            state_d = MAC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    coef_wr = coef_we && coef_ready && (32'(coef_addr) < 32'(N));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      vout_q  <= 1'b0;
      for (int i = 0; i < K; i++) dline_q[i] <= '0;
      for (int i = 0; i < N; i++) coef_q[i] <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      if (accept) begin
        for (int i = K - 1; i > 0; i--) dline_q[i] <= dline_q[i-1];
        dline_q[0] <= data_in;
      end
      if (coef_wr) coef_q[coef_addr] <= coef_data;
    end
  end

  assign data_out  = dout_q;
  assign valid_out = vout_q;

endmodule

// File: tb/tb_polyphase_interpolator.sv
// Directed bench for polyphase_interpolator (N=31, M=2, K=16); expected values are hand-computed.
module tb_polyphase_interpolator;
  localparam int SW = 16;
  localparam int CW = 16;
  localparam int N  = 31;
  localparam int M  = 2;

`ifdef ROUND_EN
  localparam int EXP_PSEL  = 2000;
  localparam int EXP_FLOOR = -1;
  localparam int EXP_GATE  = 1000;
`else
  localparam int EXP_PSEL  = 1999;
  localparam int EXP_FLOOR = -2;
  localparam int EXP_GATE  = 999;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 valid_in;
  logic                 ready_in;
  logic signed [SW-1:0] data_in;
  logic                 valid_out;
  logic                 ready_out;
  logic signed [SW-1:0] data_out;
  logic                 coef_we;
  logic [4:0]           coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 coef_ready;

  int cyc = 0;
  int n_checks = 0;
  int n_fails = 0;

  polyphase_interpolator #(.SAMPLE_WIDTH(SW), .COEF_WIDTH(CW), .N(N), .M(M)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_ready(coef_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = 5'(addr);
    coef_data = CW'(val);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic send(input int d, output int tacc);
    int n = 0;
    valid_in = 1'b1;
    data_in  = SW'(d);
    while (!ready_in && n < 300) begin
      tick();
      n++;
    end
    check("accept", ready_in, 1);
    tacc = cyc;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid_out && n < 300) begin
      tick();
      n++;
    end
    check(tag, valid_out, 1);
  endtask

  task automatic get_out(input string tag, output logic signed [SW-1:0] d, output int t);
    wait_valid(tag);
    d = data_out;
    t = cyc;
    tick();
  endtask

  initial begin
    logic signed [SW-1:0] o0, o1;
    int ta, tb, t0, t1;

    reset = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    tick();
    tick();
    check("rst_ready_in", ready_in, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_coef_ready", coef_ready, 0);
    reset = 1'b0;
    #1;
    check("idle_ready_in", ready_in, 1);
    check("idle_coef_ready", coef_ready, 1);

    // Impulse response and latency/throughput
    write_coef(0, 16384);
    send(1000, ta);
    get_out("imp_a0_vld", o0, t0);
    get_out("imp_a1_vld", o1, t1);
    check("imp_a_p0", o0, 500);
    check("imp_a_p1", o1, 0);
    check("imp_lat_p0", t0 - ta, 17);
    check("imp_lat_p1", t1 - ta, 34);
    check("imp_b2b_ready", ready_in, 1);
    send(0, tb);
    check("imp_throughput", tb - ta, 35);
    get_out("imp_b0_vld", o0, t0);
    get_out("imp_b1_vld", o1, t1);
    check("imp_b_p0", o0, 0);
    check("imp_b_p1", o1, 0);

    // Negative input: floor vs round toward +inf at -1.5
    send(-3, ta);
    get_out("neg_0_vld", o0, t0);
    get_out("neg_1_vld", o1, t1);
    check("neg_p0", o0, EXP_FLOOR);
    check("neg_p1", o1, 0);

    // Phase select
    do_reset();
    write_coef(1, 32767);
    send(2000, ta);
    get_out("psel_0_vld", o0, t0);
    get_out("psel_1_vld", o1, t1);
    check("psel_p0", o0, 0);
    check("psel_p1", o1, EXP_PSEL);

    // Multi-tap mix across both phases
    do_reset();
    write_coef(0, 16384);
    write_coef(2, -8192);
    write_coef(3, 8192);
    send(100, ta);
    get_out("mix_a0_vld", o0, t0);
    get_out("mix_a1_vld", o1, t1);
    check("mix_a_p0", o0, 50);
    check("mix_a_p1", o1, 0);
    send(200, ta);
    get_out("mix_b0_vld", o0, t0);
    get_out("mix_b1_vld", o1, t1);
    check("mix_b_p0", o0, 75);
    check("mix_b_p1", o1, 25);

    // Saturation, both rails
    do_reset();
    for (int i = 0; i < N; i++) write_coef(i, 32767);
    for (int i = 0; i < 16; i++) begin
      send(32767, ta);
      get_out("satp_0_vld", o0, t0);
      get_out("satp_1_vld", o1, t1);
      if (i == 0) check("sat_first_p0", o0, 32766);
    end
    check("sat_pos_p0", o0, 32767);
    check("sat_pos_p1", o1, 32767);
    for (int i = 0; i < 16; i++) begin
      send(-32768, ta);
      get_out("satn_0_vld", o0, t0);
      get_out("satn_1_vld", o1, t1);
    end
    check("sat_neg_p0", o0, -32768);
    check("sat_neg_p1", o1, -32768);

    // Backpressure on phase 0
    do_reset();
    write_coef(0, 16384);
    write_coef(1, 8192);
    ready_out = 1'b0;
    send(600, ta);
    wait_valid("bp_vld");
    check("bp_data_first", data_out, 300);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", valid_out, 1);
      check("bp_hold_data", data_out, 300);
      check("bp_hold_ready_in", ready_in, 0);
    end
    ready_out = 1'b1;
    tick();
    check("bp_consumed", valid_out, 0);
    get_out("bp_p1_vld", o1, t1);
    check("bp_p1", o1, 150);
    for (int i = 0; i < 3; i++) begin
      check("bp_no_dup", valid_out, 0);
      tick();
    end
    check("bp_idle_ready_in", ready_in, 1);

    // Coefficient write gating
    do_reset();
    write_coef(0, 16384);
    send(1000, ta);
    coef_we = 1'b1; coef_addr = 5'd0; coef_data = 16'sd32767;
    #1;
    check("gate_coef_ready_mac", coef_ready, 0);
    tick();
    coef_we = 1'b0;
    get_out("gate_a0_vld", o0, t0);
    get_out("gate_a1_vld", o1, t1);
    check("gate_dropped_p0", o0, 500);
    check("gate_idle_coef_ready", coef_ready, 1);
    write_coef(0, 32767);
    send(1000, ta);
    get_out("gate_b0_vld", o0, t0);
    get_out("gate_b1_vld", o1, t1);
    check("gate_taken_p0", o0, EXP_GATE);
    check("gate_taken_p1", o1, 0);

    // Simultaneous sample and coefficient write in IDLE
    valid_in = 1'b1; data_in = '0;
    coef_we = 1'b1; coef_addr = 5'd2; coef_data = 16'sd16384;
    #1;
    check("simul_ready_in", ready_in, 1);
    tick();
    valid_in = 1'b0; coef_we = 1'b0;
    get_out("simul_0_vld", o0, t0);
    get_out("simul_1_vld", o1, t1);
    check("simul_p0", o0, 500);
    check("simul_p1", o1, 0);

    // Reset mid-MAC at tap 7
    do_reset();
    write_coef(0, 16384);
    send(1000, ta);
    for (int i = 0; i < 7; i++) tick();
    check("mid_busy_ready_in", ready_in, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mid_valid_out", valid_out, 0);
    check("mid_ready_in", ready_in, 1);
    check("mid_data_out", data_out, 0);
    send(1000, ta);
    get_out("mid_0_vld", o0, t0);
    get_out("mid_1_vld", o1, t1);
    check("mid_cleared_p0", o0, 0);
    check("mid_cleared_p1", o1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
